latch_q_sync_filter: RTL

- Downstream consumer of a level-sensitive D latch output Q, which changes asynchronously whenever the latch enable is open.
- Synchronises Q into the clk domain and glitch-filters it.
- Detects rising and falling edges on the filtered value and presents each edge as an event record on a valid/ready handshake.
- Keeps a saturating edge count and a sticky overflow flag.

---
 rtl/latch_q_sync_filter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/latch_q_sync_filter.sv
// latch_q_sync_filter
//
// Purpose:
//   Brings the output Q of a level-sensitive D latch into the clk domain.
//   Q_in is first synchronised, then glitch-filtered. Rising and falling
//   edges of the filtered value become one-cycle pulses and event records
//   on a valid/ready handshake. A saturating edge counter and a sticky
//   overflow flag are also kept.
//
// Parameters:
//   SYNC_STAGES  depth of the synchroniser flop chain (>= 2)
//   FILT_CYCLES  consecutive mismatching cycles needed before Q_filt follows (>= 1)
//   CNT_W        width of the saturating edge counter
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   Q_in        in   latch output Q, asynchronous to clk
//   clr         in   synchronous clear of evt_cnt, overflow and evt_valid
//   Q_filt      out  synchronised and filtered copy of Q_in
//   rise_pulse  out  one-cycle pulse on a filtered 0->1 transition
//   fall_pulse  out  one-cycle pulse on a filtered 1->0 transition
//   evt_valid   out  an event record is pending
//   evt_edge    out  edge type of the pending record (1 = rise, 0 = fall)
//   evt_ready   in   consumer accepts the pending record
//   evt_cnt     out  saturating count of filtered edges
//   overflow    out  sticky: an edge was dropped while a record was pending

module latch_q_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Q_in,
  input  logic             clr,
  output logic             Q_filt,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             evt_valid,
  output logic             evt_edge,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             overflow
);

  localparam int                FCNT_W    = $clog2(FILT_CYCLES) + 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [FCNT_W-1:0]      fcnt;
  logic                   mismatch;
  logic                   take;
  state_t                 state;
  state_t                 state_next;
  logic                   load_rec;
  logic                   drop_rec;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign mismatch = sync_out ^ Q_filt;
  // A filtered edge: the synchronised value has disagreed with Q_filt for
  // FILT_CYCLES cycles in a row, counting this one.
  assign take     = mismatch && (fcnt == FCNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Q_in};
    end
  end

  // Any agreement between sync_out and Q_filt restarts the count, so only
  // an unbroken run of mismatches can move Q_filt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt   <= '0;
      Q_filt <= 1'b0;
    end else if (!mismatch) begin
      fcnt   <= '0;
    end else if (take) begin
      fcnt   <= '0;
      Q_filt <= sync_out;
    end else begin
      fcnt   <= fcnt + 1'b1;
    end
  end

  // Pulses are registered from the same condition that updates Q_filt, so
  // they line up with the new Q_filt value and ignore clr and the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= take & sync_out;
      fall_pulse <= take & ~sync_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // clr beats a coincident edge. In PEND an accepted record and a new edge
  // in the same cycle keep us in PEND with the new record.
  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (take) state_next = PEND;
        PEND:    if (evt_ready && !take) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    evt_valid = (state == PEND);
    load_rec  = !clr && take && ((state == IDLE) || evt_ready);
    drop_rec  = !clr && take && (state == PEND) && !evt_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_edge <= 1'b0;
    end else if (load_rec) begin
      evt_edge <= sync_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (drop_rec) begin
      overflow <= 1'b1;
    end
  end

  // Dropped edges are still counted; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt <= '0;
    end else if (clr) begin
      evt_cnt <= '0;
    end else if (take && (evt_cnt != CNT_MAX)) begin
      evt_cnt <= evt_cnt + 1'b1;
    end
  end

endmodule
